// File: rtl/ram_loader_if.sv
// Byte-stream and RAM-write bundle between the UART receiver, ram_loader and the program RAM.
// No logic: wiring only, zero latency.
// in_valid/in_ready handshake on the byte side; the RAM write side is a plain strobe.
interface ram_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_d;
  logic        mem_wr;

  // Environment side: drives bytes, observes RAM writes.
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_d, mem_wr
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_d, mem_wr
  );
endinterface

// File: rtl/ram_loader.sv
// Serial boot loader: assembles LE 32-bit words from a byte frame and writes them to RAM.
// Latency: mem_wr one cycle after the 4th byte of a word; done/err one cycle after the last byte.
// Backpressure: never stalls; in_ready is low only in the cycle after reset.
// Optional trailing checksum byte enabled by defining RAM_LOADER_CKSUM_EN.
module ram_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned WORDS_MAX = 8192,
  parameter logic [7:0]  MAGIC     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  ram_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  // Address bits [1:0] are ignored so every write is word aligned.
  localparam logic [15:0] BASE_AL = {BASE_ADDR[15:2], 2'b00};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_FIN,
    S_ERR
`ifdef RAM_LOADER_CKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        in_ready_q;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_d_q, mem_d_d;
  logic        mem_wr_q, mem_wr_d;
`ifdef RAM_LOADER_CKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic        accept;
  logic [15:0] len_w;
  logic [31:0] word_w;
  logic [15:0] idx_inc;

  assign accept  = bus.in_valid && in_ready_q;
  assign len_w   = {bus.in_data, len_q[7:0]};
  // Bytes arrive LSB first, so each new byte enters at the top and older ones shift down.
  assign word_w  = {bus.in_data, word_q[31:8]};
  assign idx_inc = idx_q + 16'd1;

  assign bus.in_ready = in_ready_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_d    = mem_d_q;
  assign bus.mem_wr   = mem_wr_q;

  // Frame parser: next state, word assembly, write request and status decode.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    idx_d      = idx_q;
    len_d      = len_q;
    word_d     = word_q;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    mem_wr_d   = 1'b0;
`ifdef RAM_LOADER_CKSUM_EN
    sum_d      = sum_q;
`endif
    cpu_hold   = (state_q != S_IDLE);
    done       = (state_q == S_FIN);
    err        = (state_q == S_ERR);

    case (state_q)
      S_IDLE: begin
        if (accept && (bus.in_data == MAGIC)) begin
          state_d = S_LEN0;
          lane_d  = 2'd0;
          idx_d   = 16'd0;
`ifdef RAM_LOADER_CKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d   = {8'h00, bus.in_data};
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = len_w;
          if (32'(len_w) > WORDS_MAX) begin
            state_d = S_ERR;
          end else if (len_w == 16'd0) begin
`ifdef RAM_LOADER_CKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_FIN;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = word_w;
          lane_d = lane_q + 2'd1;
`ifdef RAM_LOADER_CKSUM_EN
          sum_d  = sum_q + bus.in_data;
`endif
          if (lane_q == 2'd3) begin
            mem_wr_d   = 1'b1;
            mem_d_d    = word_w;
            mem_addr_d = BASE_AL + {idx_q[13:0], 2'b00};
            idx_d      = idx_inc;
            if (idx_inc == len_q) begin
`ifdef RAM_LOADER_CKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_FIN;
`endif
            end
          end
        end
      end
`ifdef RAM_LOADER_CKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (8'(sum_q + bus.in_data) == 8'h00) ? S_FIN : S_ERR;
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any partially assembled word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      lane_q     <= 2'd0;
      idx_q      <= 16'd0;
      len_q      <= 16'd0;
      word_q     <= 32'd0;
      mem_addr_q <= BASE_AL;
      mem_d_q    <= 32'd0;
      mem_wr_q   <= 1'b0;
`ifdef RAM_LOADER_CKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= 1'b1;
      lane_q     <= lane_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      word_q     <= word_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      mem_wr_q   <= mem_wr_d;
`ifdef RAM_LOADER_CKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (base 0000 and FFFC) share one byte stream.
// A frame-level model predicts the RAM writes and done/err pulses of each instance.
module tb_ram_loader;
  localparam logic [7:0]  MAGIC     = 8'hA5;
  localparam int          WORDS_MAX = 8192;
  localparam logic [15:0] BASE0     = 16'h0000;
  localparam logic [15:0] BASE1     = 16'hFFFC;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       hold0, done0_o, err0_o;
  logic       hold1, done1_o, err1_o;

  ram_loader_if if0 ();
  ram_loader_if if1 ();

  assign if0.in_data  = in_data;
  assign if0.in_valid = in_valid;
  assign if1.in_data  = in_data;
  assign if1.in_valid = in_valid;

  ram_loader #(.BASE_ADDR(BASE0), .WORDS_MAX(WORDS_MAX), .MAGIC(MAGIC)) dut0 (
    .clk(clk), .reset(reset), .bus(if0),
    .cpu_hold(hold0), .done(done0_o), .err(err0_o)
  );
  ram_loader #(.BASE_ADDR(BASE1), .WORDS_MAX(WORDS_MAX), .MAGIC(MAGIC)) dut1 (
    .clk(clk), .reset(reset), .bus(if1),
    .cpu_hold(hold1), .done(done1_o), .err(err1_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Observed side (written only by the monitor).
  wr_t obs0[$];
  wr_t obs1[$];
  int  obs0c[$];
  int  ndone0 = 0, nerr0 = 0, ndone1 = 0, nerr1 = 0;
  int  last_done0 = -1;
  bit  hold_log [0:8191];

  // Expected side (written only by the model).
  wr_t        exp0[$];
  wr_t        exp1[$];
  int         exp_done = 0, exp_err = 0;
  logic [7:0] tx_q[$];
  logic [31:0] fix_q[$];
  int         acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.mem_wr) begin
      obs0.push_back({if0.mem_addr, if0.mem_d});
      obs0c.push_back(cyc);
    end
    if (if1.mem_wr) obs1.push_back({if1.mem_addr, if1.mem_d});
    if (done0_o) begin
      ndone0     <= ndone0 + 1;
      last_done0 <= cyc;
    end
    if (err0_o)  nerr0  <= nerr0 + 1;
    if (done1_o) ndone1 <= ndone1 + 1;
    if (err1_o)  nerr1  <= nerr1 + 1;
    hold_log[cyc % 8192] <= hold0;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Frame model: appends the frame bytes to tx_q and the predicted writes/outcome.
  task automatic add_frame(input int n, input bit bad_ck);
    logic [31:0] w;
    logic [15:0] off;
`ifdef RAM_LOADER_CKSUM_EN
    logic [7:0] s;
    logic [7:0] ck;
    s = 8'd0;
`endif
    tx_q.push_back(MAGIC);
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
    if (n > WORDS_MAX) begin
      exp_err++;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = (fix_q.size() > 0) ? fix_q.pop_front() : $urandom();
      for (int b = 0; b < 4; b++) begin
        tx_q.push_back(w[8*b +: 8]);
`ifdef RAM_LOADER_CKSUM_EN
        s = s + w[8*b +: 8];
`endif
      end
      off = 16'(4 * i);
      exp0.push_back({16'(BASE0 + off), w});
      exp1.push_back({16'(BASE1 + off), w});
    end
`ifdef RAM_LOADER_CKSUM_EN
    ck = 8'd0 - s;
    if (bad_ck) ck = ck + 8'd1;
    tx_q.push_back(ck);
    if (bad_ck) exp_err++;
    else exp_done++;
`else
    exp_done++;
`endif
  endtask

  function automatic int wr_bad(input int dut, input int fo, input int fe);
    int bad = 0;
    if (dut == 0) begin
      for (int i = 0; (fo + i) < obs0.size() && (fe + i) < exp0.size(); i++)
        if (obs0[fo + i] !== exp0[fe + i]) bad++;
    end else begin
      for (int i = 0; (fo + i) < obs1.size() && (fe + i) < exp1.size(); i++)
        if (obs1[fo + i] !== exp1[fe + i]) bad++;
    end
    return bad;
  endfunction

  // gap_mode: 0 = one byte per cycle, 1 = valid every other cycle, 2 = random 0..2 idle cycles.
  task automatic send_all(input int gap_mode);
    int tries;
    int ng;
    acc_q.delete();
    foreach (tx_q[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = tx_q[i];
      tries = 0;
      while (!(if0.in_ready && if1.in_ready) && tries < 50) begin
        @(negedge clk);
        tries++;
      end
      if (tries >= 50) begin
        tests++;
        fails++;
        $display("FAIL in_ready_timeout: in_ready stayed %b/%b, required 1", if0.in_ready, if1.in_ready);
      end
      acc_q.push_back(cyc);
      ng = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      repeat (ng) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    tx_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({if0.in_ready, if0.mem_wr, hold0, done0_o, err0_o, if0.mem_d, if0.mem_addr} !== {5'b0, 32'd0, BASE0}) begin
      fails++;
      $display("FAIL reset_dut0: got rdy=%b wr=%b hold=%b done=%b err=%b d=%h a=%h, required all 0 and a=%h",
               if0.in_ready, if0.mem_wr, hold0, done0_o, err0_o, if0.mem_d, if0.mem_addr, BASE0);
    end
    tests++;
    if ({if1.in_ready, if1.mem_wr, hold1, done1_o, err1_o, if1.mem_d, if1.mem_addr} !== {5'b0, 32'd0, BASE1}) begin
      fails++;
      $display("FAIL reset_dut1: got rdy=%b wr=%b d=%h a=%h, required 0 0 0 and a=%h",
               if1.in_ready, if1.mem_wr, if1.mem_d, if1.mem_addr, BASE1);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({if0.in_ready, if1.in_ready} !== 2'b11) begin
      fails++;
      $display("FAIL ready_after_reset: got %b%b, required 11", if0.in_ready, if1.in_ready);
    end
  endtask

  task automatic test_basic;
    int fo0 = obs0.size(), fe0 = exp0.size(), fo1 = obs1.size(), fe1 = exp1.size();
    int d0 = ndone0;
    int dn;
    logic [3:0] hv;
    fix_q.push_back(32'h12345678);
    fix_q.push_back(32'hDEADBEEF);
    add_frame(2, 1'b0);
    send_all(0);
    idle(4);
    tests++;
    if (obs0.size() - fo0 !== 2) begin
      fails++;
      $display("FAIL basic_wr_count: got %0d writes, required 2", obs0.size() - fo0);
    end
    tests++;
    if (wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1) !== 0) begin
      fails++;
      $display("FAIL basic_wr_data: %0d writes differ from model, required 0", wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1));
    end
    tests++;
    if (ndone0 - d0 !== 1) begin
      fails++;
      $display("FAIL basic_done: got %0d done pulses, required 1", ndone0 - d0);
    end
    if (obs0.size() - fo0 >= 2) begin
      tests++;
      if ({obs0c[fo0], obs0c[fo0 + 1]} !== {acc_q[6] + 1, acc_q[10] + 1}) begin
        fails++;
        $display("FAIL basic_wr_timing: got cycles %0d,%0d required %0d,%0d",
                 obs0c[fo0], obs0c[fo0 + 1], acc_q[6] + 1, acc_q[10] + 1);
      end
    end
`ifdef RAM_LOADER_CKSUM_EN
    dn = acc_q[11] + 1;
`else
    dn = acc_q[10] + 1;
`endif
    tests++;
    if (last_done0 !== dn) begin
      fails++;
      $display("FAIL basic_done_timing: got cycle %0d, required %0d", last_done0, dn);
    end
    hv = {hold_log[acc_q[0] % 8192], hold_log[(acc_q[0] + 1) % 8192], hold_log[dn % 8192], hold_log[(dn + 1) % 8192]};
    tests++;
    if (hv !== 4'b0110) begin
      fails++;
      $display("FAIL basic_cpu_hold: got %b (at A5, after A5, done, after done), required 0110", hv);
    end
    tests++;
    if ({if0.mem_wr, if0.mem_d, if0.mem_addr} !== {1'b0, 32'hDEADBEEF, 16'h0004}) begin
      fails++;
      $display("FAIL basic_hold_values: got wr=%b d=%h a=%h, required 0 deadbeef 0004", if0.mem_wr, if0.mem_d, if0.mem_addr);
    end
  endtask

  task automatic test_noise_zero;
    int fo0 = obs0.size(), fo1 = obs1.size();
    int d0 = ndone0, e0 = nerr0;
    tx_q.push_back(8'h00);
    tx_q.push_back(8'hFF);
    add_frame(0, 1'b0);
    send_all(0);
    idle(4);
    tests++;
    if ((obs0.size() - fo0) + (obs1.size() - fo1) !== 0) begin
      fails++;
      $display("FAIL zero_len_writes: got %0d writes, required 0", (obs0.size() - fo0) + (obs1.size() - fo1));
    end
    tests++;
    if ({ndone0 - d0, nerr0 - e0} !== {32'd1, 32'd0}) begin
      fails++;
      $display("FAIL zero_len_status: got done=%0d err=%0d, required 1 0", ndone0 - d0, nerr0 - e0);
    end
  endtask

  task automatic test_oversize;
    int fo0 = obs0.size(), fe0 = exp0.size(), fo1 = obs1.size(), fe1 = exp1.size();
    int d0 = ndone0, e0 = nerr0;
    add_frame(WORDS_MAX + 1, 1'b0);
    send_all(0);
    idle(3);
    tests++;
    if ({obs0.size() - fo0, nerr0 - e0, ndone0 - d0} !== {32'd0, 32'd1, 32'd0}) begin
      fails++;
      $display("FAIL oversize: got writes=%0d err=%0d done=%0d, required 0 1 0", obs0.size() - fo0, nerr0 - e0, ndone0 - d0);
    end
    tests++;
    if (hold0 !== 1'b0) begin
      fails++;
      $display("FAIL oversize_idle: cpu_hold=%b, required 0", hold0);
    end
    add_frame(1, 1'b0);
    send_all(0);
    idle(4);
    tests++;
    if (obs0.size() - fo0 !== 1 || wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1) !== 0 || ndone0 - d0 !== 1) begin
      fails++;
      $display("FAIL after_oversize: got writes=%0d bad=%0d done=%0d, required 1 0 1",
               obs0.size() - fo0, wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1), ndone0 - d0);
    end
  endtask

`ifdef RAM_LOADER_CKSUM_EN
  task automatic test_checksum;
    int fo0 = obs0.size(), fe0 = exp0.size(), fo1 = obs1.size(), fe1 = exp1.size();
    int d0 = ndone0, e0 = nerr0;
    fix_q.push_back(32'h04030201);
    add_frame(1, 1'b0);
    send_all(0);
    idle(3);
    tests++;
    if ({ndone0 - d0, nerr0 - e0} !== {32'd1, 32'd0}) begin
      fails++;
      $display("FAIL cksum_pass: got done=%0d err=%0d, required 1 0", ndone0 - d0, nerr0 - e0);
    end
    fix_q.push_back(32'h04030201);
    add_frame(1, 1'b1);
    send_all(0);
    idle(3);
    tests++;
    if ({ndone0 - d0, nerr0 - e0} !== {32'd1, 32'd1}) begin
      fails++;
      $display("FAIL cksum_fail: got done=%0d err=%0d, required 1 1", ndone0 - d0, nerr0 - e0);
    end
    tests++;
    if (obs0.size() - fo0 !== 2 || wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1) !== 0) begin
      fails++;
      $display("FAIL cksum_writes: got writes=%0d bad=%0d, required 2 0", obs0.size() - fo0, wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1));
    end
  endtask
`endif

  task automatic test_reset_mid;
    int fo0 = obs0.size(), fe0 = exp0.size(), fo1 = obs1.size(), fe1 = exp1.size();
    int d0 = ndone0, e0 = nerr0;
    tx_q.push_back(MAGIC);
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    send_all(0);
    reset = 1'b1;
    idle(2);
    tests++;
    if ({if0.in_ready, if0.mem_wr, hold0, done0_o, err0_o, if0.mem_d, if0.mem_addr} !== {5'b0, 32'd0, BASE0}) begin
      fails++;
      $display("FAIL reset_mid_values: got rdy=%b wr=%b hold=%b d=%h a=%h, required 0 0 0 0 %h",
               if0.in_ready, if0.mem_wr, hold0, if0.mem_d, if0.mem_addr, BASE0);
    end
    reset = 1'b0;
    idle(1);
    add_frame(1, 1'b0);
    send_all(0);
    idle(4);
    tests++;
    if (obs0.size() - fo0 !== 1 || obs1.size() - fo1 !== 1 || wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1) !== 0) begin
      fails++;
      $display("FAIL reset_mid_writes: got writes=%0d/%0d bad=%0d, required 1/1 0",
               obs0.size() - fo0, obs1.size() - fo1, wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1));
    end
    tests++;
    if ({ndone0 - d0, nerr0 - e0} !== {32'd1, 32'd0}) begin
      fails++;
      $display("FAIL reset_mid_status: got done=%0d err=%0d, required 1 0", ndone0 - d0, nerr0 - e0);
    end
  endtask

  task automatic test_gapped_wrap;
    int fo1 = obs1.size(), fe1 = exp1.size();
    int d1 = ndone1;
    add_frame(2, 1'b0);
    send_all(1);
    idle(4);
    tests++;
    if (obs1.size() - fo1 !== 2 || wr_bad(1, fo1, fe1) !== 0 || ndone1 - d1 !== 1) begin
      fails++;
      $display("FAIL gapped_wrap: got writes=%0d bad=%0d done=%0d, required 2 0 1",
               obs1.size() - fo1, wr_bad(1, fo1, fe1), ndone1 - d1);
    end
    if (obs1.size() - fo1 >= 2) begin
      tests++;
      if ({obs1[fo1].a, obs1[fo1 + 1].a} !== {16'hFFFC, 16'h0000}) begin
        fails++;
        $display("FAIL wrap_addr: got %h,%h required fffc,0000", obs1[fo1].a, obs1[fo1 + 1].a);
      end
    end
  endtask

  task automatic test_random;
    int fo0 = obs0.size(), fe0 = exp0.size(), fo1 = obs1.size(), fe1 = exp1.size();
    int ed = exp_done, ee = exp_err, d0 = ndone0, e0 = nerr0, d1 = ndone1, e1 = nerr1;
    logic [7:0] nb;
    bit bad;
    for (int f = 0; f < 16; f++) begin
      repeat ($urandom_range(0, 3)) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == MAGIC) nb = 8'h00;
        tx_q.push_back(nb);
      end
`ifdef RAM_LOADER_CKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`else
      bad = 1'b0;
`endif
      if ($urandom_range(0, 7) == 0) add_frame(WORDS_MAX + $urandom_range(1, 500), bad);
      else add_frame($urandom_range(0, 6), bad);
      send_all($urandom_range(0, 2));
      idle(3);
    end
    tests++;
    if (obs0.size() - fo0 !== exp0.size() - fe0 || obs1.size() - fo1 !== exp1.size() - fe1) begin
      fails++;
      $display("FAIL random_wr_count: got %0d/%0d, required %0d", obs0.size() - fo0, obs1.size() - fo1, exp0.size() - fe0);
    end
    tests++;
    if (wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1) !== 0) begin
      fails++;
      $display("FAIL random_wr_data: %0d writes differ from model, required 0", wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1));
    end
    tests++;
    if ({ndone0 - d0, nerr0 - e0, ndone1 - d1, nerr1 - e1} !== {exp_done - ed, exp_err - ee, exp_done - ed, exp_err - ee}) begin
      fails++;
      $display("FAIL random_status: got done=%0d err=%0d, required done=%0d err=%0d",
               ndone0 - d0, nerr0 - e0, exp_done - ed, exp_err - ee);
    end
  endtask

  task automatic test_max_len;
    int fo0 = obs0.size(), fe0 = exp0.size(), fo1 = obs1.size(), fe1 = exp1.size();
    int d0 = ndone0, e0 = nerr0;
    add_frame(WORDS_MAX, 1'b0);
    send_all(0);
    idle(4);
    tests++;
    if (obs0.size() - fo0 !== WORDS_MAX || wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1) !== 0) begin
      fails++;
      $display("FAIL max_len_writes: got writes=%0d bad=%0d, required %0d 0",
               obs0.size() - fo0, wr_bad(0, fo0, fe0) + wr_bad(1, fo1, fe1), WORDS_MAX);
    end
    tests++;
    if ({ndone0 - d0, nerr0 - e0} !== {32'd1, 32'd0}) begin
      fails++;
      $display("FAIL max_len_status: got done=%0d err=%0d, required 1 0", ndone0 - d0, nerr0 - e0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_noise_zero();
    test_oversize();
`ifdef RAM_LOADER_CKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    test_gapped_wrap();
    test_random();
    test_max_len();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
